// File: rtl/time_set_ctrl_if.sv
// Front-panel and counter-preset bundle for the time-setting controller.
// The controller owns the slave side; the clock core/panel owns the master side.
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [6:0] cur_hour;
  logic [6:0] cur_min;
  logic [6:0] cur_sec;
  logic       run_en;
  logic       load_hour;
  logic       load_min;
  logic       load_sec;
  logic [6:0] data_hour;
  logic [6:0] data_min;
  logic [6:0] data_sec;
  logic [1:0] sel;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, btn_dec,
    output cur_hour, cur_min, cur_sec,
    input  run_en, load_hour, load_min, load_sec,
    input  data_hour, data_min, data_sec,
    input  sel, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec,
    input  cur_hour, cur_min, cur_sec,
    output run_en, load_hour, load_min, load_sec,
    output data_hour, data_min, data_sec,
    output sel, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: debounced buttons drive an hour/min/sec edit FSM.
// Optional auto-repeat of inc/dec is built only with TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl #(
  parameter int DEB_CYCLES    = 4,
  parameter int BLINK_DIV     = 8,
  parameter int REPEAT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_HOUR,
    S_MIN,
    S_SEC,
    S_COMMIT
  } state_t;

  state_t state, state_n;

  logic [2:0] raw;
  logic [2:0] press;

  assign raw = {bus.btn_dec, bus.btn_inc, bus.btn_mode};

  // bit 0 = mode, 1 = inc, 2 = dec
  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic          s1;
    logic          s2;
    logic          lvl;
    logic          lvl_q;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_q <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[g];
        s2    <= s1;
        lvl_q <= lvl;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DW'(DEB_CYCLES - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    assign press[g] = lvl & ~lvl_q;
  end

  logic       run_q;
  logic       ld_q;
  logic [1:0] sel_q;
  logic [1:0] sel_n;
  logic       blink_q;
  logic [BW-1:0] div;
  logic [6:0] sh_h, sh_m, sh_s;
  logic [6:0] sh_h_n, sh_m_n, sh_s_n;

  logic mode_ev;
  logic inc_any, dec_any;
  logic inc_ev, dec_ev;
  logic rep_inc, rep_dec;

  assign mode_ev = press[0];

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_hold;
  logic          rep_fire;

  // a fresh press or a field change restarts the initial delay
  assign rep_hold = (sel_q != 2'd0)
                 && (g_deb[1].lvl ^ g_deb[2].lvl)
                 && !mode_ev && !press[1] && !press[2];
  assign rep_fire = rep_hold && (rep_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !rep_hold || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  assign rep_inc = rep_fire & g_deb[1].lvl;
  assign rep_dec = rep_fire & g_deb[2].lvl;
`else
  assign rep_inc = (REPEAT_CYCLES < 0);
  assign rep_dec = (REPEAT_CYCLES < 0);
`endif

  assign inc_any = press[1] | rep_inc;
  assign dec_any = press[2] | rep_dec;
  assign inc_ev  = inc_any & ~dec_any & ~mode_ev;
  assign dec_ev  = dec_any & ~inc_any & ~mode_ev;

  function automatic logic [6:0] clip(
    input logic [6:0] v,
    input logic [6:0] top
  );
    return (v > top) ? 7'd0 : v;
  endfunction

  function automatic logic [6:0] up(
    input logic [6:0] v,
    input logic [6:0] top
  );
    return (v >= top) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [6:0] dn(
    input logic [6:0] v,
    input logic [6:0] top
  );
    return (v == 7'd0 || v > top) ? top : v - 7'd1;
  endfunction

  always_comb begin
    state_n = state;
    sh_h_n  = sh_h;
    sh_m_n  = sh_m;
    sh_s_n  = sh_s;
    unique case (state)
      S_RUN: begin
        if (mode_ev) begin
          state_n = S_HOUR;
          sh_h_n  = clip(bus.cur_hour, 7'd23);
          sh_m_n  = clip(bus.cur_min, 7'd59);
          sh_s_n  = clip(bus.cur_sec, 7'd59);
        end
      end
      S_HOUR: begin
        if (mode_ev) state_n = S_MIN;
        else if (inc_ev) sh_h_n = up(sh_h, 7'd23);
        else if (dec_ev) sh_h_n = dn(sh_h, 7'd23);
      end
      S_MIN: begin
        if (mode_ev) state_n = S_SEC;
        else if (inc_ev) sh_m_n = up(sh_m, 7'd59);
        else if (dec_ev) sh_m_n = dn(sh_m, 7'd59);
      end
      S_SEC: begin
        if (mode_ev) state_n = S_COMMIT;
        else if (inc_ev) sh_s_n = up(sh_s, 7'd59);
        else if (dec_ev) sh_s_n = dn(sh_s, 7'd59);
      end
      S_COMMIT: state_n = S_RUN;
      default:  state_n = S_RUN;
    endcase
  end

  always_comb begin
    sel_n = 2'd0;
    unique case (state_n)
      S_HOUR:  sel_n = 2'd1;
      S_MIN:   sel_n = 2'd2;
      S_SEC:   sel_n = 2'd3;
      default: sel_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      run_q   <= 1'b1;
      ld_q    <= 1'b0;
      sel_q   <= 2'd0;
      blink_q <= 1'b0;
      div     <= '0;
      sh_h    <= 7'd0;
      sh_m    <= 7'd0;
      sh_s    <= 7'd0;
    end else begin
      state <= state_n;
      run_q <= (state_n == S_RUN);
      ld_q  <= (state_n == S_COMMIT);
      sel_q <= sel_n;
      sh_h  <= sh_h_n;
      sh_m  <= sh_m_n;
      sh_s  <= sh_s_n;
      if (sel_n == 2'd0) begin
        blink_q <= 1'b0;
        div     <= '0;
      end else if (sel_n != sel_q) begin
        blink_q <= 1'b1;
        div     <= '0;
      end else if (div == BW'(BLINK_DIV - 1)) begin
        blink_q <= ~blink_q;
        div     <= '0;
      end else begin
        div <= div + BW'(1);
      end
    end
  end

  assign bus.run_en    = run_q;
  assign bus.load_hour = ld_q;
  assign bus.load_min  = ld_q;
  assign bus.load_sec  = ld_q;
  assign bus.data_hour = sh_h;
  assign bus.data_min  = sh_m;
  assign bus.data_sec  = sh_s;
  assign bus.sel       = sel_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed edit scenarios plus random button
// sequences checked against an event-level model of the edit rules.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int REP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  time_set_ctrl_if bus ();

  time_set_ctrl #(
    .DEB_CYCLES(DEB),
    .BLINK_DIV(BLK),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int n_ld = 0;
  int n_full = 0;
  int n_ld_run = 0;
  int ld_h = 0, ld_m = 0, ld_s = 0;
  int m_f = 0;
  int m_ld = 0;
  int e_h = 0, e_m = 0, e_s = 0;
  int sh [4] = '{0, 0, 0, 0};

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.load_hour || bus.load_min || bus.load_sec) begin
      n_ld++;
      if (bus.load_hour && bus.load_min && bus.load_sec) n_full++;
      if (bus.run_en) n_ld_run++;
      ld_h = int'(bus.data_hour);
      ld_m = int'(bus.data_min);
      ld_s = int'(bus.data_sec);
    end
  end

  function automatic int lim(input int f);
    return (f == 1) ? 24 : 60;
  endfunction

  task automatic model_mode();
    if (m_f == 0) begin
      sh[1] = (bus.cur_hour > 23) ? 0 : int'(bus.cur_hour);
      sh[2] = (bus.cur_min > 59) ? 0 : int'(bus.cur_min);
      sh[3] = (bus.cur_sec > 59) ? 0 : int'(bus.cur_sec);
      m_f = 1;
    end else if (m_f == 3) begin
      m_ld++;
      e_h = sh[1];
      e_m = sh[2];
      e_s = sh[3];
      m_f = 0;
    end else begin
      m_f++;
    end
  endtask

  task automatic model_step(input bit is_inc);
    if (m_f != 0) begin
      if (is_inc) sh[m_f] = (sh[m_f] + 1) % lim(m_f);
      else sh[m_f] = (sh[m_f] + lim(m_f) - 1) % lim(m_f);
    end
  endtask

  task automatic drive(input logic [2:0] m);
    bus.btn_mode = m[0];
    bus.btn_inc  = m[1];
    bus.btn_dec  = m[2];
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int mi, input int s);
    bus.cur_hour = 7'(h);
    bus.cur_min  = 7'(mi);
    bus.cur_sec  = 7'(s);
  endtask

  // m: bit0 mode, bit1 inc, bit2 dec
  task automatic press(input logic [2:0] m, input int hold);
    if (m[0]) model_mode();
    else if (m[1] ^ m[2]) model_step(m[1]);
    drive(m);
    tick(hold);
    drive(3'b000);
    tick(DEB + 4);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".sel"}, bus.sel, m_f);
    chk({tag, ".run"}, bus.run_en, (m_f == 0));
    chk({tag, ".hr"}, bus.data_hour, sh[1]);
    chk({tag, ".mn"}, bus.data_min, sh[2]);
    chk({tag, ".sc"}, bus.data_sec, sh[3]);
    chk({tag, ".nld"}, n_ld, m_ld);
    chk({tag, ".nfull"}, n_full, m_ld);
    chk({tag, ".ldrun"}, n_ld_run, 0);
    if (m_f == 0) chk({tag, ".blink"}, bus.blink, 0);
    if (m_ld > 0) begin
      chk({tag, ".ld_h"}, ld_h, e_h);
      chk({tag, ".ld_m"}, ld_m, e_m);
      chk({tag, ".ld_s"}, ld_s, e_s);
    end
  endtask

  task automatic to_run();
    while (m_f != 0) press(3'b001, 6);
  endtask

  initial begin
    drive(3'b000);
    set_cur(0, 0, 0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(50);
    check_state("idle");

    // main edit walk
    set_cur(13, 45, 7);
    press(3'b001, 6);
    check_state("first_mode");
    repeat (3) press(3'b010, 7);
    press(3'b001, 6);
    press(3'b100, 8);
    press(3'b001, 6);
    check_state("in_sec");
    press(3'b001, 6);
    check_state("commit");
    chk("walk.h", ld_h, 16);
    chk("walk.m", ld_m, 44);
    chk("walk.s", ld_s, 7);

    // wrap boundaries
    set_cur(23, 0, 59);
    press(3'b001, 6);
    press(3'b010, 6);
    press(3'b001, 6);
    press(3'b100, 6);
    press(3'b001, 6);
    press(3'b010, 6);
    press(3'b001, 6);
    check_state("wrap");
    chk("wrap.h", ld_h, 0);
    chk("wrap.m", ld_m, 59);
    chk("wrap.s", ld_s, 0);

    // glitch rejection and exact press latency
    set_cur(5, 20, 30);
    press(3'b001, 6);
    drive(3'b010); tick(2);
    drive(3'b000); tick(1);
    drive(3'b010); tick(3);
    drive(3'b000); tick(10);
    chk("glitch", bus.data_hour, sh[1]);
    drive(3'b010); tick(6);
    drive(3'b000);
    chk("edge_n5", bus.data_hour, sh[1]);
    tick(1);
    model_step(1'b1);
    chk("edge_n6", bus.data_hour, sh[1]);
    tick(10);
    check_state("clean");

    // field change restarts blink high for BLK cycles
    drive(3'b001); tick(6);
    drive(3'b000);
    chk("blk.sel0", bus.sel, 1);
    tick(1);
    model_mode();
    chk("blk.sel1", bus.sel, 2);
    chk("blk.start", bus.blink, 1);
    tick(BLK - 1);
    chk("blk.hold", bus.blink, 1);
    tick(1);
    chk("blk.tog", bus.blink, 0);
    tick(BLK);
    chk("blk.tog2", bus.blink, 1);
    check_state("blk");

    // reset mid-edit
    to_run();
    set_cur(5, 30, 0);
    press(3'b001, 6);
    press(3'b001, 6);
    check_state("pre_rst");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_f = 0;
    sh = '{0, 0, 0, 0};
    check_state("post_rst");
    tick(5);
    chk("post_rst.nld", n_ld, m_ld);

    // long hold in SET_SEC
    set_cur(1, 2, 10);
    repeat (3) press(3'b001, 6);
    drive(3'b010); tick(100);
    drive(3'b000); tick(DEB + 4);
`ifdef TIME_SET_AUTOREPEAT_EN
    sh[3] = (10 + 1 + (100 - 1) / REP) % 60;
`else
    sh[3] = 11;
`endif
    check_state("hold");
    to_run();
    check_state("hold_done");

    // random sequences
    for (int i = 0; i < 60; i++) begin
      int pick;
      logic [2:0] m;
      set_cur($urandom_range(0, 30), $urandom_range(0, 70),
              $urandom_range(0, 70));
      pick = $urandom_range(0, 9);
      if (pick < 3) m = 3'b001;
      else if (pick < 6) m = 3'b010;
      else if (pick < 8) m = 3'b100;
      else if (pick == 8) m = 3'b110;
      else m = 3'b101;
      press(m, $urandom_range(6, 12));
      check_state("rnd");
    end
    to_run();
    check_state("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the digital clock: the writer side of the hour/minute/second counters' preset interface. It debounces three front-panel buttons and walks an edit FSM through hour, minute and second fields. It drives each counter's `load`/`data` preset port and its count enable (`en`), so an edited time is loaded atomically and counting then resumes.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples needed to accept a button level change (≥1).
- `BLINK_DIV`, default 8: cycles per `blink` half-period while editing (≥1).
- `REPEAT_CYCLES`, default 16: auto-repeat initial delay and repeat period (used only with `TIME_SET_AUTOREPEAT_EN`).
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `btn_mode` in 1: raw async button, cycles through edit fields.
- `btn_inc` in 1: raw async button, increment the selected field.
- `btn_dec` in 1: raw async button, decrement the selected field.
- `cur_hour` in 7: live hour counter value, 0..23.
- `cur_min` in 7: live minute counter value, 0..59.
- `cur_sec` in 7: live second counter value, 0..59.
- `run_en` out 1: count enable to all three counters.
- `load_hour` out 1: one-cycle preset pulse to the hour counter.
- `load_min` out 1: one-cycle preset pulse to the minute counter.
- `load_sec` out 1: one-cycle preset pulse to the second counter.
- `data_hour` out 7: preset value for the hour counter (shadow register).
- `data_min` out 7: preset value for the minute counter (shadow register).
- `data_sec` out 7: preset value for the second counter (shadow register).
- `sel` out 2: field being edited; 0 = none, 1 = hour, 2 = minute, 3 = second.
- `blink` out 1: display blink for the selected field.

## Operation
- Each button input passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level updates after `DEB_CYCLES` consecutive synchronized samples differ from it.
  - A press event is the debounced rising edge. Releases generate no event.
- FSM states: RUN → SET_HOUR → SET_MIN → SET_SEC → COMMIT → RUN.
  - Each `btn_mode` event advances one state.
  - COMMIT lasts exactly one cycle, then the FSM returns to RUN unconditionally.
- RUN → SET_HOUR: shadows capture `cur_hour`/`cur_min`/`cur_sec` on the same edge. `run_en` drops to 0.
- In a SET_* state:
  - An inc event adds 1 to the selected shadow, wrapping 23→0 (hour) or 59→0 (min/sec).
  - A dec event subtracts 1, wrapping 0→23 or 0→59.
  - Other shadows are unchanged.
- COMMIT:
  - `load_hour`, `load_min` and `load_sec` are all 1 for that single cycle. `data_*` hold the shadows.
  - `run_en` is 0 in COMMIT and 1 from the following cycle.
- In RUN:
  - inc/dec events are ignored.
  - `data_*` keep their last shadow values.
  - `run_en` = 1, `sel` = 0, `blink` = 0.
- Simultaneous events:
  - mode together with inc/dec: mode wins, inc/dec are dropped.
  - inc together with dec: both are dropped.
- `blink`:
  - Toggles every `BLINK_DIV` cycles in SET_* states.
  - Its divider clears and `blink` restarts at 1 on every field change.
  - `blink` is 0 in RUN and COMMIT.
- Shadow arithmetic is 7-bit and wraps explicitly. Out-of-range `cur_*` values (>23 / >59) are captured as 0.

## Timing
- Reset values:
  - Outputs: `run_en`=1, all `load_*`=0, all `data_*`=0, `sel`=0, `blink`=0.
  - Internal: FSM in RUN, synchronizers, debouncers and counters cleared.
- Reset mid-edit: returns to RUN on that edge, emits no load pulse, and discards the shadows.
- Press latency: with a raw button high from edge n and stable, the event acts (FSM/shadow update visible) after edge n+2+`DEB_CYCLES`.
- `load_*`, `data_*`, `run_en`, `sel` and `blink` are all registered outputs.

## Configuration
- `TIME_SET_AUTOREPEAT_EN` defined:
  - While inc or dec stays debounced-high in a SET_* state, one repeat event is generated after `REPEAT_CYCLES` cycles, then one every `REPEAT_CYCLES` cycles.
  - Repeats stop on release, on a mode event, or if both buttons are held.
- `TIME_SET_AUTOREPEAT_EN` undefined: exactly one event per press, and no repeat counter is built.

## Test plan
- Reset, then idle 50 cycles → `run_en`=1, `sel`=0, no `load_*` pulse, `data_*`=0.
- `cur`=13:45:07; mode, inc×3, mode, dec, mode, mode → a single cycle with all `load_*`=1 and data 16:44:07. `run_en`=0 from the first mode until the COMMIT cycle, and 1 from the next cycle.
- Wrap: hour 23 + inc → 0; min 0 + dec → 59; sec 59 + inc → 0.
- Glitchy `btn_inc` (high for 2 cycles, low, high for 3 cycles; `DEB_CYCLES`=4) → no event. A clean high for 6 cycles → exactly one increment, at edge n+6.
- Assert `rst` in SET_MIN with shadows 05:30:00 → RUN on the next edge, no load pulse, `data_*`=0, `run_en`=1.
- With `TIME_SET_AUTOREPEAT_EN`, hold inc in SET_SEC from 10 for 100 debounced cycles (`REPEAT_CYCLES`=16) → 1 + 6 increments, shadow = 17. Without the macro → 11.
